// File: rtl/elf_ioctl_loader_if.sv
// Handshake bundle between hps_io ioctl download, the loader and the ELF RAM arbiter.
interface elf_ioctl_loader_if #(
    parameter int ADDR_W = 16
);
    logic              ioctl_download;
    logic [7:0]        ioctl_index;
    logic              ioctl_wr;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic              ioctl_wait;
    logic              mem_req;
    logic              mem_gnt;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              mem_we;

    modport master (
        output ioctl_download,
        output ioctl_index,
        output ioctl_wr,
        output ioctl_addr,
        output ioctl_dout,
        output mem_gnt,
        input  ioctl_wait,
        input  mem_req,
        input  mem_addr,
        input  mem_data,
        input  mem_we
    );

    modport slave (
        input  ioctl_download,
        input  ioctl_index,
        input  ioctl_wr,
        input  ioctl_addr,
        input  ioctl_dout,
        input  mem_gnt,
        output ioctl_wait,
        output mem_req,
        output mem_addr,
        output mem_data,
        output mem_we
    );
endinterface

// File: rtl/elf_ioctl_loader.sv
// Cosmac ELF BIN loader: buffers ioctl bytes in a small FIFO and writes them
// into RAM via request/grant while holding the CPU in reset.
module elf_ioctl_loader #(
    parameter int         ADDR_W     = 16,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] LOAD_INDEX = 8'd1
) (
    input  logic              clk,
    input  logic              reset,
    elf_ioctl_loader_if.slave bus,
    output logic              cpu_hold,
    output logic              load_done,
    output logic [ADDR_W:0]   load_len,
    output logic              load_err
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [7:0]        fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              wait_q;

    logic              non_empty;
    logic              full;
    logic              in_range;
    logic              start;
    logic              pop;
    logic              push;
    logic              drop;
    logic [ADDR_W:0]   byte_end;

    assign non_empty = count != '0;
    assign full      = count == CNT_W'(FIFO_DEPTH);
    assign in_range  = (bus.ioctl_addr >> ADDR_W) == 25'd0;
    assign start     = bus.ioctl_download
                     && (bus.ioctl_index == LOAD_INDEX);
    assign pop       = non_empty && bus.mem_gnt;

    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign push = (state == LOAD) && bus.ioctl_wr
               && in_range && (!full || pop);
    assign drop = (state == LOAD) && bus.ioctl_wr && !push;

    assign byte_end = {1'b0, bus.ioctl_addr[ADDR_W-1:0]}
                    + (ADDR_W+1)'(1);

    assign bus.mem_req    = non_empty;
    assign bus.mem_we     = non_empty;
    assign bus.mem_addr   = fifo_addr[rd_ptr];
    assign bus.mem_data   = fifo_data[rd_ptr];
    assign bus.ioctl_wait = wait_q;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= bus.ioctl_addr[ADDR_W-1:0];
            fifo_data[wr_ptr] <= bus.ioctl_dout;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cpu_hold  <= 1'b0;
            load_done <= 1'b0;
            load_len  <= '0;
            load_err  <= 1'b0;
            wait_q    <= 1'b0;
        end else begin
            load_done <= 1'b0;
            wait_q    <= 1'b0;
            if (push && (byte_end > load_len)) begin
                load_len <= byte_end;
            end
            if (drop) begin
                load_err <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        cpu_hold <= 1'b1;
                        load_len <= '0;
                        load_err <= 1'b0;
                    end
                end
                LOAD: begin
                    if (!bus.ioctl_download) begin
                        state <= DRAIN;
                    end else begin
                        // Leave one slot for a strobe already in flight.
                        wait_q <= count >= CNT_W'(FIFO_DEPTH - 1);
                    end
                end
                DRAIN: begin
                    if (!non_empty) begin
                        state     <= DONE;
                        load_done <= 1'b1;
                        cpu_hold  <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
